// File: rtl/noise_pkg.sv
// Shared constants and FSM state type for the DAC noise histogrammer.
package noise_pkg;

  localparam int unsigned NBINS = 17;
  localparam int unsigned IDX_W = 5;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDrain,
    StDump
  } state_e;

endpackage

// File: rtl/popcount16.sv
// Combinational population count of a 16-bit word (result 0..16).
module popcount16
  import noise_pkg::*;
(
  input  logic [15:0]      din,
  output logic [IDX_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < 16; i++) begin
      count = count + IDX_W'(din[i]);
    end
  end

endmodule

// File: rtl/noise_histogram.sv
// Histogram of DAC-line popcounts over a window of samples, read out bin by bin
// through a valid/ready handshake.
module noise_histogram
  import noise_pkg::*;
#(
  parameter int unsigned NSAMP_W = 20,
  parameter int unsigned CNT_W   = 20
) (
  input  logic               sclk,
  input  logic               reset,
  input  logic               start,
  input  logic [NSAMP_W-1:0] nsamples,
  input  logic [15:0]        dac,
  output logic               busy,
  output logic               bin_valid,
  input  logic               bin_ready,
  output logic [IDX_W-1:0]   bin_index,
  output logic [CNT_W-1:0]   bin_count,
  output logic               done
);

  state_e             state_q, state_d;
  logic [NSAMP_W-1:0] len_q, len_d;
  logic [NSAMP_W-1:0] scnt_q, scnt_d;
  logic [IDX_W-1:0]   pc;
  logic [IDX_W-1:0]   pc_q;
  logic               pc_vld_q, pc_vld_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               done_q, done_d;
  logic               clear_bins;
  logic               accept;
  logic               last_sample;
  logic               last_bin;
  logic [CNT_W-1:0]   bins_q [NBINS];

  popcount16 u_popcount (
    .din   (dac),
    .count (pc)
  );

  assign accept      = bin_valid && bin_ready;
  assign last_sample = (scnt_q == len_q - NSAMP_W'(1));
  assign last_bin    = (idx_q == IDX_W'(NBINS - 1));

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    scnt_d     = scnt_q;
    idx_d      = idx_q;
    done_d     = 1'b0;
    pc_vld_d   = 1'b0;
    clear_bins = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d      = nsamples;
          scnt_d     = '0;
          idx_d      = '0;
          clear_bins = 1'b1;
          state_d    = (nsamples == '0) ? StDump : StAccum;
        end
      end
      StAccum: begin
        pc_vld_d = 1'b1;
        scnt_d   = scnt_q + NSAMP_W'(1);
        if (last_sample) state_d = StDrain;
      end
      // Lets the increment for the final registered sample land before readout.
      StDrain: state_d = StDump;
      StDump: begin
        if (accept) begin
          if (last_bin) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      len_q    <= '0;
      scnt_q   <= '0;
      pc_q     <= '0;
      pc_vld_q <= 1'b0;
      idx_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      scnt_q   <= scnt_d;
      pc_vld_q <= pc_vld_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      if (pc_vld_d) pc_q <= pc;
    end
  end

  // Register array so a new window can zero every bin in one cycle.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < NBINS; b++) bins_q[b] <= '0;
    end else if (clear_bins) begin
      for (int b = 0; b < NBINS; b++) bins_q[b] <= '0;
    end else if (pc_vld_q) begin
      for (int b = 0; b < NBINS; b++) begin
        if (pc_q == IDX_W'(b) && bins_q[b] != '1) bins_q[b] <= bins_q[b] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    bin_count = '0;
    for (int b = 0; b < NBINS; b++) begin
      if (idx_q == IDX_W'(b)) bin_count = bins_q[b];
    end
  end

  assign busy      = (state_q != StIdle);
  assign bin_valid = (state_q == StDump);
  assign bin_index = idx_q;
  assign done      = done_q;

endmodule

// File: tb/tb_noise_histogram.sv
// Directed bench for noise_histogram: scoreboarded bin readout, stalls, saturation, reset abort.
module tb_noise_histogram;

  logic        sclk = 1'b0;
  logic        reset;
  logic        start;
  logic [19:0] nsamples;
  logic [15:0] dac;
  logic        bin_ready;

  logic        busy, bin_valid, done;
  logic [4:0]  bin_index;
  logic [19:0] bin_count;

  logic        busy3, bin_valid3, done3;
  logic [4:0]  bin_index3;
  logic [2:0]  bin_count3;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  int exp3_q[$];
  int done_cnt = 0;
  int done_base = 0;

  noise_histogram #(.NSAMP_W(20), .CNT_W(20)) dut (
    .sclk      (sclk),
    .reset     (reset),
    .start     (start),
    .nsamples  (nsamples),
    .dac       (dac),
    .busy      (busy),
    .bin_valid (bin_valid),
    .bin_ready (bin_ready),
    .bin_index (bin_index),
    .bin_count (bin_count),
    .done      (done)
  );

  noise_histogram #(.NSAMP_W(20), .CNT_W(3)) dut3 (
    .sclk      (sclk),
    .reset     (reset),
    .start     (start),
    .nsamples  (nsamples),
    .dac       (dac),
    .busy      (busy3),
    .bin_valid (bin_valid3),
    .bin_ready (bin_ready),
    .bin_index (bin_index3),
    .bin_count (bin_count3),
    .done      (done3)
  );

  always #5 sclk = ~sclk;

  always @(negedge sclk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic dump_check(input string tag, input bit rnd, input bit chk3);
    int          got = 0;
    int          cyc = 0;
    bit          stalled = 0;
    bit          rdy;
    int          ev, ev3;
    logic [4:0]  hi;
    logic [19:0] hc;
    logic [2:0]  hc3;
    while (got < 17 && cyc < 200) begin
      @(negedge sclk);
      cyc++;
      if (bin_valid === 1'b1) begin
        if (stalled) begin
          check({tag, "/stall_idx"}, bin_index, hi);
          check({tag, "/stall_cnt"}, bin_count, hc);
        end
        rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        bin_ready = rdy;
        if (rdy) begin
          ev  = exp_q.pop_front();
          ev3 = exp3_q.pop_front();
          check($sformatf("%s/idx%0d", tag, got), bin_index, got);
          check($sformatf("%s/bin%0d", tag, got), bin_count, ev);
          if (chk3) check($sformatf("%s/sat_bin%0d", tag, got), bin_count3, ev3);
          got++;
          stalled = 0;
        end else begin
          stalled = 1;
          hi  = bin_index;
          hc  = bin_count;
          hc3 = bin_count3;
        end
      end else begin
        bin_ready = 1'b0;
      end
    end
    check({tag, "/delivered"}, got, 17);
    exp_q.delete();
    exp3_q.delete();
    @(negedge sclk);
    bin_ready = 1'b0;
    #1;
    check({tag, "/done_hi"}, done, 1);
    check({tag, "/busy_lo"}, busy, 0);
    check({tag, "/valid_lo"}, bin_valid, 0);
    check({tag, "/done_cnt"}, done_cnt - done_base, 1);
    @(negedge sclk);
    #1;
    check({tag, "/done_lo"}, done, 0);
  endtask

  // mode 0: samples alternate a/b; mode 1: random samples.
  task automatic run_window(input string tag, input int n, input logic [15:0] a,
                            input logic [15:0] b, input bit mode, input bit rnd,
                            input bit chk3, input bit mid);
    int          e[17];
    logic [15:0] d;
    for (int k = 0; k < 17; k++) e[k] = 0;
    @(negedge sclk);
    start     = 1'b1;
    nsamples  = 20'(n);
    done_base = done_cnt;
    @(negedge sclk);
    start = 1'b0;
    #1;
    check({tag, "/busy"}, busy, 1);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge sclk);
      d   = mode ? 16'($urandom) : ((i % 2) != 0 ? b : a);
      dac = d;
      e[$countones(d)]++;
      if (mid && i == 10) begin
        start    = 1'b1;
        nsamples = 20'd3;
      end else begin
        start = 1'b0;
      end
    end
    for (int k = 0; k < 17; k++) begin
      exp_q.push_back(e[k]);
      exp3_q.push_back(e[k] > 7 ? 7 : e[k]);
    end
    dump_check(tag, rnd, chk3);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    nsamples  = '0;
    dac       = '0;
    bin_ready = 1'b0;
    #1;
    check("rst/busy", busy, 0);
    check("rst/valid", bin_valid, 0);
    check("rst/done", done, 0);
    check("rst/idx", bin_index, 0);
    check("rst/cnt", bin_count, 0);
    repeat (2) @(negedge sclk);
    reset = 1'b0;

    run_window("all0", 10, 16'h0000, 16'h0000, 0, 0, 0, 0);
    run_window("allF", 5, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0);
    run_window("alt", 6, 16'h00FF, 16'h0001, 0, 0, 0, 0);
    run_window("zero", 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
    run_window("rndrdy", 30, 16'h0000, 16'h0000, 1, 1, 0, 0);
    run_window("sat", 20, 16'h0000, 16'h0000, 0, 0, 1, 1);

    // Abort a window with reset after three samples.
    @(negedge sclk);
    start     = 1'b1;
    nsamples  = 20'd10;
    done_base = done_cnt;
    @(negedge sclk);
    start = 1'b0;
    dac   = 16'h5555;
    repeat (3) @(negedge sclk);
    reset = 1'b1;
    #1;
    check("abort/busy", busy, 0);
    check("abort/valid", bin_valid, 0);
    check("abort/done", done, 0);
    check("abort/idx", bin_index, 0);
    check("abort/cnt", bin_count, 0);
    repeat (2) @(negedge sclk);
    reset = 1'b0;
    repeat (20) @(negedge sclk);
    #1;
    check("abort/no_done", done_cnt - done_base, 0);
    run_window("recover", 4, 16'h0003, 16'h0003, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/noise_histogram.md
NOISE_HISTOGRAM -- requirements
Module: noise_histogram

Interface
REQ-001 Parameter NSAMP_W, default 20: width of the sample-window length.
REQ-002 Parameter CNT_W, default 20: width of each histogram bin counter.
REQ-003 sclk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a measurement window.
REQ-006 nsamples  input  NSAMP_W  window length in samples; latched when start is accepted.
REQ-007 dac  input  16  the 16 noise-generator DAC lines; each line weighs 1.
REQ-008 busy  output  1  high from start acceptance until done.
REQ-009 bin_valid  output  1  readout bin present on bin_index and bin_count.
REQ-010 bin_ready  input  1  consumer accepts the current bin.
REQ-011 bin_index  output  5  bin number 0..16, equal to the DAC popcount value.
REQ-012 bin_count  output  CNT_W  number of samples with that popcount.
REQ-013 done  output  1  one-cycle pulse after bin 16 is accepted.

Function
REQ-014 The FSM SHALL have states IDLE, ACCUM, DRAIN and DUMP.
REQ-015 IDLE: on start=1, latch nsamples, clear all 17 bins and the sample counter in the same cycle, assert busy, and go to ACCUM; if the latched value is 0, go directly to DUMP.
REQ-016 ACCUM: sample dac on every sclk edge; stage 1 registers popcount(dac) (0..16); stage 2 increments bin[popcount] by 1.
REQ-017 Exactly nsamples consecutive dac values SHALL be sampled, starting with the first edge after start acceptance; the sample counter SHALL compare against the latched length.
REQ-018 After the last sample, the FSM SHALL go to DRAIN for exactly one cycle so that the final pipelined increment lands, then go to DUMP.
REQ-019 A bin SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-020 DUMP: bin_valid=1; bin_index starts at 0 and advances by 1 on each cycle with bin_valid&&bin_ready; bin_count equals bin[bin_index]; outputs SHALL stay stable while bin_ready=0.
REQ-021 When bin 16 is accepted, the block SHALL deassert bin_valid and busy in the next cycle, pulse done for that one cycle, and return to IDLE.
REQ-022 start SHALL be ignored while busy=1.
REQ-023 Bin contents SHALL be retained in IDLE until the next accepted start.
REQ-024 Without saturation, the sum of the 17 dumped bin_count values SHALL equal the latched nsamples.

Reset
REQ-025 reset SHALL force, asynchronously: state=IDLE, busy=0, bin_valid=0, done=0, bin_index=0, bin_count=0, all bins=0, sample counter=0, pipeline stage=0.
REQ-026 Reset during ACCUM or DUMP SHALL abort the window without a done pulse; the first start after reset deasserts SHALL behave as in REQ-015.

Structure
REQ-027 A shared package noise_pkg SHALL hold NBINS=17, the bin index width (5), and the FSM state enum.
REQ-028 Popcount SHALL be a sub-module popcount16 (16-bit in, 5-bit out, combinational), instantiated once ahead of the stage-1 register.
REQ-029 The bins SHALL be a register array, not RAM, so that they can be cleared in a single cycle.

Verification
REQ-030 dac=16'h0000, nsamples=10, bin_ready=1 -> bin0=10, bins 1..16=0, done pulses once, busy drops.
REQ-031 dac=16'hFFFF, nsamples=5 -> bin16=5, all others 0; then dac alternating 16'h00FF/16'h0001 over nsamples=6 -> bin8=3, bin1=3.
REQ-032 nsamples=0 -> DUMP is entered immediately, 17 bins of 0 are read out, and done pulses.
REQ-033 bin_ready toggled pseudo-randomly during DUMP -> every index 0..16 is delivered once, in order, with stable values while stalled.
REQ-034 CNT_W=3, dac=0, nsamples=20 -> bin0=7 (saturated); start pulsed mid-window is ignored.
REQ-035 reset asserted at sample 3 of 10 -> all outputs 0 immediately and no done pulse; a following nsamples=4 run of dac=16'h0003 -> bin2=4.
